arm_one_nios_nios_cpu_1_cpu_debug_host_seq: RTL and testbench

ARM_ONE_NIOS_NIOS_CPU_1_CPU_DEBUG_HOST_SEQ -- requirements
Module: arm_one_nios_nios_cpu_1_cpu_debug_host_seq

---
 rtl/arm_one_nios_nios_cpu_1_cpu_debug_host_seq.sv | 148 ++++++++++++++
 tb/tb_arm_one_nios_nios_cpu_1_cpu_debug_host_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_one_nios_nios_cpu_1_cpu_debug_host_seq.sv
// Host-side virtual JTAG scan sequencer: runs one UIR/CDR/SDR/UDR/RTI scan per
// accepted command and returns the captured tdo bits and instruction status.
module arm_one_nios_nios_cpu_1_cpu_debug_host_seq #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

  localparam int unsigned    CNT_W    = $clog2(DR_WIDTH + 1);
  localparam logic [8:0]     PH_RISE  = 9'(TCK_DIV);
  localparam logic [8:0]     PH_LAST  = 9'(2 * TCK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS_ALL = CNT_W'(DR_WIDTH);

  state_t              state, state_nx;
  logic [8:0]          phase;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    bit_cnt_now;
  logic [DR_WIDTH-1:0] shift;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_out_q;
  logic                tdo_q;
  logic                tdo_now;
  logic                scan;
  logic                rise;
  logic                period_end;

  assign scan       = (state inside {UIR, CDR, SDR, UDR, RTI});
  assign rise       = scan && (phase == PH_RISE);
  assign period_end = scan && (phase == PH_LAST);
  // With TCK_DIV=1 the rising cycle is also the period end, so use live values.
  assign tdo_now     = rise ? vji_tdo : tdo_q;
  assign bit_cnt_now = rise ? bit_cnt + CNT_W'(1) : bit_cnt;
  assign rsp_ir_out  = ir_out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_dr    = '0;
    busy      = 1'b1;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    vji_tdi   = 1'b0;
    vji_tck   = 1'b0;
    vji_ir_in = '0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = UIR;
      end
      UIR: begin
        vji_uir = 1'b1;
        if (period_end) state_nx = CDR;
      end
      CDR: begin
        vji_cdr = 1'b1;
        if (period_end) state_nx = SDR;
      end
      SDR: begin
        vji_sdr = 1'b1;
        vji_tdi = shift[0];
        if (period_end && (bit_cnt_now == BITS_ALL)) state_nx = UDR;
      end
      UDR: begin
        vji_udr = 1'b1;
        if (period_end) state_nx = RTI;
      end
      RTI: begin
        vji_rti = 1'b1;
        if (period_end) state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_dr    = shift;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (scan) begin
      vji_tck   = (phase >= PH_RISE);
      vji_ir_in = ir_q;
    end
  end

  // tdo is captured on the rising cycle but shifted in at period end so that
  // shift[0] (and hence vji_tdi) holds steady across the whole tck period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ir_q     <= '0;
      ir_out_q <= '0;
      tdo_q    <= 1'b0;
    end else begin
      if (scan) phase <= period_end ? 9'd0 : phase + 9'd1;
      else      phase <= '0;
      if (state == IDLE && cmd_valid) begin
        shift   <= cmd_dr;
        ir_q    <= cmd_ir;
        bit_cnt <= '0;
      end
      if (state == UIR && rise) ir_out_q <= vji_ir_out;
      if (state == SDR) begin
        if (rise) begin
          tdo_q   <= vji_tdo;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        if (period_end)
          shift <= (shift >> 1) | (DR_WIDTH'(tdo_now) << (DR_WIDTH - 1));
      end
    end
  end

endmodule

// File: tb/tb_arm_one_nios_nios_cpu_1_cpu_debug_host_seq.sv
// Scoreboard bench for the virtual JTAG scan sequencer (default and small configs).
module tb_arm_one_nios_nios_cpu_1_cpu_debug_host_seq;

  localparam int unsigned DRW  = 38;
  localparam int unsigned DIV  = 2;
  localparam int          LAT  = (DRW + 4) * 2 * DIV + 1;
  localparam int unsigned DRWB = 4;
  localparam int          LATB = (DRWB + 4) * 2 * 1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic            cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]      cmd_ir, rsp_ir_out, ir_in, ir_out;
  logic [DRW-1:0]  cmd_dr, rsp_dr;
  logic            tck, tdi, tdo, uir, cdr, sdr, udr, rti, busy;
  int              tdo_mode;
  assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? 1'b1 : ~tdi;

  logic            b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0]      b_cmd_ir, b_rsp_ir_out, b_ir_in, b_ir_out;
  logic [DRWB-1:0] b_cmd_dr, b_rsp_dr;
  logic            b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti, b_busy;
  assign b_tdo = b_tdi;

  arm_one_nios_nios_cpu_1_cpu_debug_host_seq #(.DR_WIDTH(DRW), .IR_WIDTH(2), .TCK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo),
    .vji_ir_in(ir_in), .vji_ir_out(ir_out), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr),
    .vji_udr(udr), .vji_rti(rti), .busy(busy));

  arm_one_nios_nios_cpu_1_cpu_debug_host_seq #(.DR_WIDTH(DRWB), .IR_WIDTH(2), .TCK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir(b_cmd_ir), .cmd_dr(b_cmd_dr), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir_out), .vji_tck(b_tck), .vji_tdi(b_tdi),
    .vji_tdo(b_tdo), .vji_ir_in(b_ir_in), .vji_ir_out(b_ir_out), .vji_uir(b_uir),
    .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti), .busy(b_busy));

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DRW-1:0] dr;
    logic [1:0]     ir;
  } exp_t;
  exp_t            q[$];
  exp_t            e_a;
  logic [DRWB-1:0] qb[$];

  int         cyc = 0, acc_cyc = 0, accepts = 0, responses = 0, rsp_firsts = 0;
  int         n_uir, n_cdr, n_sdr, n_udr, n_rti, ir_bad;
  logic [1:0] ir_exp;
  bit         tck_prev = 0, rsp_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      q.delete();
      rsp_seen = 0;
      tck_prev = 0;
      accepts  = responses;
    end else begin
      if (cmd_valid && cmd_ready) begin
        e_a.dr = (tdo_mode == 0) ? cmd_dr : (tdo_mode == 1) ? {DRW{1'b1}} : ~cmd_dr;
        e_a.ir = ir_out;
        q.push_back(e_a);
        acc_cyc = cyc;
        ir_exp  = cmd_ir;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; ir_bad = 0;
        accepts++;
      end
      if (tck && !tck_prev) begin
        n_uir += int'(uir); n_cdr += int'(cdr); n_sdr += int'(sdr);
        n_udr += int'(udr); n_rti += int'(rti);
        if (ir_in !== ir_exp) ir_bad++;
      end
      tck_prev = tck;
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1;
        rsp_firsts++;
        if (q.size() == 0) check_eq("rsp_unexpected", 1, 0);
        else begin
          e_a = q.pop_front();
          check_eq("rsp_dr", 64'(rsp_dr), 64'(e_a.dr));
          check_eq("rsp_ir_out", 64'(rsp_ir_out), 64'(e_a.ir));
          check_eq("latency", 64'(cyc - acc_cyc), 64'(LAT));
          check_eq("uir_rises", 64'(n_uir), 1);
          check_eq("cdr_rises", 64'(n_cdr), 1);
          check_eq("sdr_rises", 64'(n_sdr), 64'(DRW));
          check_eq("udr_rises", 64'(n_udr), 1);
          check_eq("rti_rises", 64'(n_rti), 1);
          check_eq("ir_in_during_scan", 64'(ir_bad), 0);
          check_eq("one_accept", 64'(accepts), 64'(responses + 1));
        end
      end
      if (!rsp_valid) rsp_seen = 0;
      if (rsp_valid && rsp_ready) responses++;
    end
  end

  int              b_cyc = 0, b_acc = 0, b_bits = 0, b_resps = 0;
  logic [DRWB-1:0] b_tdi_vec, e_b;
  bit              b_tck_prev = 0, b_seen = 0;

  always @(negedge clk) begin
    b_cyc++;
    if (reset_n) begin
      if (b_cmd_valid && b_cmd_ready) begin
        qb.push_back(b_cmd_dr);
        b_acc = b_cyc; b_bits = 0; b_tdi_vec = '0;
      end
      if (b_tck && !b_tck_prev && b_sdr) begin
        if (b_bits < int'(DRWB)) b_tdi_vec[b_bits] = b_tdi;
        b_bits++;
      end
      b_tck_prev = b_tck;
      if (b_rsp_valid && !b_seen) begin
        b_seen = 1;
        if (qb.size() == 0) check_eq("b_rsp_unexpected", 1, 0);
        else begin
          e_b = qb.pop_front();
          check_eq("b_rsp_dr", 64'(b_rsp_dr), 64'(e_b));
          check_eq("b_tdi_seq", 64'(b_tdi_vec), 64'(e_b));
          check_eq("b_sdr_bits", 64'(b_bits), 64'(DRWB));
          check_eq("b_latency", 64'(b_cyc - b_acc), 64'(LATB));
          check_eq("b_rsp_ir_out", 64'(b_rsp_ir_out), 64'(b_ir_out));
        end
      end
      if (!b_rsp_valid) b_seen = 0;
      if (b_rsp_valid && b_rsp_ready) b_resps++;
    end
  end

  task automatic send_a(input logic [1:0] ir, input logic [DRW-1:0] dr);
    int n = 0;
    @(posedge clk); #1;
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
    while (!cmd_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) check_eq("timeout_accept", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string tag);
    int n = 0;
    while (responses < target && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) check_eq(tag, 0, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int             r, bad, n;
  logic [DRW-1:0] dr_r;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
    tdo_mode = 0; ir_out = 2'b00;
    b_cmd_valid = 1'b0; b_cmd_ir = '0; b_cmd_dr = '0; b_rsp_ready = 1'b1; b_ir_out = 2'b11;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 1);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 0);
    check_eq("rst_tck_tdi", 64'({tck, tdi}), 0);
    check_eq("rst_strobes", 64'({uir, cdr, sdr, udr, rti}), 0);
    check_eq("rst_ir", 64'({ir_in, rsp_ir_out}), 0);
    check_eq("rst_rsp_dr", 64'(rsp_dr), 0);
    check_eq("rst_b_cmd_ready", 64'(b_cmd_ready), 1);
    reset_n = 1'b1;

    // loopback: data returns unchanged
    r = responses;
    send_a(2'b01, 38'h2A_5555_5555);
    wait_resp(r + 1, "timeout_loopback");

    // tdo tied high
    tdo_mode = 1; ir_out = 2'b10; r = responses;
    send_a(2'b10, 38'h12_3456_789A);
    wait_resp(r + 1, "timeout_tdo_high");

    // inverted tdo with response held back for 20 cycles
    tdo_mode = 2; ir_out = 2'($urandom_range(0, 3)); rsp_ready = 1'b0;
    dr_r = DRW'({$urandom(), $urandom()});
    send_a(2'b11, dr_r);
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    if (n >= 2000) check_eq("timeout_hold", 0, 1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!rsp_valid || rsp_dr !== ~dr_r || cmd_ready || tck) bad++;
      @(posedge clk); #1;
    end
    check_eq("resp_hold_stable", 64'(bad), 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("resp_release_idle", 64'({cmd_ready, rsp_valid, busy}), 64'(3'b100));
    rsp_ready = 1'b1;

    // reset in the middle of SDR
    tdo_mode = 0; ir_out = 2'b01;
    send_a(2'b10, DRW'({$urandom(), $urandom()}));
    n = 0;
    while (!(sdr && n_sdr >= 10) && n < 2000) begin @(posedge clk); #1; n++; end
    check_eq("abort_in_sdr", 64'(sdr), 1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_tck", 64'(tck), 0);
    check_eq("abort_strobes", 64'({uir, cdr, sdr, udr, rti}), 0);
    check_eq("abort_idle", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
    r = rsp_firsts;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (200) @(posedge clk); #1;
    check_eq("abort_no_rsp", 64'(rsp_firsts), 64'(r));
    r = responses;
    send_a(2'b01, DRW'({$urandom(), $urandom()}));
    wait_resp(r + 1, "timeout_after_abort");

    // cmd_valid held across two scans
    tdo_mode = 1; ir_out = 2'b11; r = responses;
    @(posedge clk); #1;
    cmd_ir = 2'b11; cmd_dr = 38'h00_0F0F_F0F0; cmd_valid = 1'b1;
    wait_resp(r + 2, "timeout_hold_valid");
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_eq("hold_accepts", 64'(accepts), 64'(responses));

    // small configuration, TCK_DIV=1
    r = b_resps;
    @(posedge clk); #1;
    b_cmd_ir = 2'b01; b_cmd_dr = 4'b1011; b_cmd_valid = 1'b1;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    n = 0;
    while (b_resps < r + 1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) check_eq("timeout_b", 0, 1);

    repeat (5) @(posedge clk); #1;
    check_eq("queue_a_empty", 64'(q.size()), 0);
    check_eq("queue_b_empty", 64'(qb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
